// File: rtl/mem_access_pkg.sv
// ============================================================================
// mem_access_pkg : shared encodings for the data-memory access unit
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

  localparam int MEM_BYTES_DEF = 128;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// mem_lane_align : big-endian lane extract/extend for loads, lane merge for stores
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_in[31:24];
    case (off)
      2'd0:    byte_v = word_in[31:24];
      2'd1:    byte_v = word_in[23:16];
      2'd2:    byte_v = word_in[15:8];
      default: byte_v = word_in[7:0];
    endcase
    half_v = off[1] ? word_in[15:0] : word_in[31:16];

    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
      SZ_HALF: load_data = {{16{sign_ext & half_v[15]}}, half_v};
      default: load_data = word_in;
    endcase

    // Untouched lanes keep the word read back from memory.
    store_word = word_in;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    store_word[31:24] = wdata[7:0];
          2'd1:    store_word[23:16] = wdata[7:0];
          2'd2:    store_word[15:8]  = wdata[7:0];
          default: store_word[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) store_word[15:0]  = wdata[15:0];
        else        store_word[31:16] = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : load/store sequencer for a big-endian 32-bit data memory
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [31:0] aligned_addr;
  logic [32:0] last_byte;
  logic        align_err;
  logic        range_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign aligned_addr = {addr[31:2], 2'b00};
  assign last_byte    = {1'b0, aligned_addr} + 33'd3;
  assign range_err    = last_byte >= 33'(MEM_BYTES);

  always_comb begin
    align_err = 1'b0;
    case (size)
      SZ_BYTE: align_err = 1'b0;
      SZ_HALF: align_err = addr[0];
      SZ_WORD: align_err = |addr[1:0];
      default: align_err = 1'b1;
    endcase
  end

  mem_lane_align u_align (
    .word_in    (mem_rdata),
    .off        (off_q),
    .size       (size_q),
    .sign_ext   (sext_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d       = we;
          size_d     = size;
          sext_d     = sign_ext;
          off_d      = addr[1:0];
          wdata_d    = wdata;
          mem_addr_d = aligned_addr;
          err_d      = align_err | range_err;
          if (align_err | range_err) begin
            state_d = ST_DONE;
          end else if (we && (size == SZ_WORD)) begin
            mem_wdata_d = wdata;
            state_d     = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        // The merged word is registered here so it is settled for the whole WR cycle.
        if (we_q) begin
          mem_wdata_d = store_word;
          state_d     = ST_WR;
        end else begin
          rdata_d = load_data;
          state_d = ST_DONE;
        end
      end
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sext_q      <= 1'b0;
      off_q       <= 2'd0;
      wdata_q     <= 32'd0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) & err_q;
  assign mem_rd    = (state_q == ST_RD);
  assign mem_wr    = (state_q == ST_WR);
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the CPU data-memory interface. It accepts one load/store request from the multi-cycle control unit and sequences the strobes to the byte-addressed, big-endian 32-bit data memory.
- Memory read is combinational; memory write is performed on the falling clock edge.
- Handles byte, halfword and word accesses, sign/zero extension, and read-modify-write for sub-word stores.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
MEM_BYTES, 128, memory size in bytes; valid accesses satisfy aligned_word_addr + 3 < MEM_BYTES.

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  reset, synchronous, active-high
req  in  1  request strobe from control unit; sampled only in IDLE
we  in  1  1 = store, 0 = load
size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal
sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  in  32  byte address
wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done: misaligned, illegal size, or out of range
rdata  out  32  load result; holds until the next successful load completes
mem_addr  out  32  word-aligned address (addr & ~3) latched at accept
mem_wdata  out  32  full word to write
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable
mem_rdata  in  32  memory read data; big-endian, byte at offset 0 = [31:24]

Behaviour:
- Reset values: state IDLE; busy, done, err, mem_rd, mem_wr = 0; rdata, mem_addr, mem_wdata = 0.
- Request capture: in IDLE with req=1, latch we, size, sign_ext, addr[1:0], wdata, and aligned address. req is ignored in all other states.
- States: IDLE, RD, WR, DONE. mem_rd=1 only in RD; mem_wr=1 only in WR; the two are never high together. done=1 only in DONE.
- Error check at accept:
  - size=11, half with addr[0]=1, or word with addr[1:0]!=0 is an error.
  - aligned addr + 3 >= MEM_BYTES is an error.
  - On error: IDLE->DONE with err=1; no mem_rd/mem_wr; rdata unchanged.
- Load: IDLE->RD->DONE->IDLE.
  - rdata is registered at the end of RD from mem_rdata by lane select.
  - Byte offset k selects bits [31-8k -: 8].
  - Half offset 0 selects [31:16]; half offset 2 selects [15:0].
  - Result is extended per sign_ext.
  - done is high 2 cycles after the accept edge.
- Word store: IDLE->WR->DONE. mem_wdata = wdata.
- Sub-word store: IDLE->RD->WR->DONE.
  - In RD, capture mem_rdata.
  - In WR, mem_wdata = captured word with the selected lane(s) replaced by wdata[7:0] or wdata[15:0]; other bytes are unchanged.
- mem_addr and mem_wdata are stable for the whole RD/WR cycle, so the falling-edge write sees settled data.
- DONE always returns to IDLE. A new req is accepted the cycle after done at the earliest.
- Reset mid-operation: next rising edge forces IDLE, strobes drop, and no done is produced. A write whose WR cycle already saw its falling edge is not undone.

Decomposition:
- Package mem_access_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state encoding, default MEM_BYTES.
- One combinational sub-module, mem_lane_align: load lane extract + extension, and store lane merge, keyed by offset/size. The FSM stays in mem_access_unit.

Test Plan:
Memory model preloaded with word 0x812345F6 at 0x10, other locations 0.
1. Word load: lw 0x10 -> mem_rd for exactly 1 cycle with mem_addr=0x10; done 2 cycles after accept; rdata=0x812345F6, err=0.
2. Sub-word loads:
   - lb 0x10 signed -> 0xFFFFFF81.
   - lbu 0x13 -> 0x000000F6.
   - lh 0x12 signed -> 0x000045F6.
   - lhu 0x10 -> 0x00008123.
3. Byte store: sb 0x11 with wdata=0x000000AB -> RD then WR, mem_wdata=0x81AB45F6, done 3 cycles after accept. A following lw 0x10 returns 0x81AB45F6.
4. Error cases, each giving done+err on the next cycle with no mem_rd/mem_wr and rdata unchanged:
   - sw 0x12 (misaligned word).
   - lh 0x11 (misaligned half).
   - lw 0x80 (out of range).
   - size=11 (illegal).
5. Reset mid-operation: rst asserted during RD of an sh -> busy=0 and mem_rd=0 after the edge; no mem_wr and no done. A subsequent lw 0x10 completes normally.
6. Request handling: req held high continuously for loads -> one accept per 3 cycles; req pulses while busy have no effect on state or outputs.
